nn_sample_loader: RTL and testbench

Upstream feeder for the neural-network top (controller plus 10-neuron datapath). It accepts one test sample per transaction as a byte stream on a valid/ready interface: 62 feature bytes, then 1 label byte. It packs the features into the 496-bit `test_data` word, pulses `start`, and waits for the network's `ready`. It then captures the 8-bit class output, compares it with the label, and reports per-sample results and running accuracy counters.

---
 rtl/nn_sample_loader.sv | 162 ++++++++++++++++
 tb/tb_nn_sample_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_sample_loader.sv
// nn_sample_loader
// Feeds one test sample per transaction to the neural-network top. Each sample arrives as N
// feature bytes followed by one label byte on a valid/ready stream. The features are packed
// into nn_data, the network is started, and its class output is compared with the label.
// Per-sample results and saturating accuracy counters are reported.
//
// Ports:
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   in_valid/ready  byte stream handshake, in_data carries feature/label bytes
//   nn_data         packed features, feature k at [k*DW +: DW]
//   nn_start        one-cycle start pulse to the network
//   nn_ready        network result valid (level), nn_class its class output
//   res_valid/ready result handshake; res_class, res_label, res_match, res_timeout held
//   clr_stats       synchronous clear of sample_cnt/correct_cnt
//   sample_cnt      completed samples, correct_cnt matched samples (both saturating)
module nn_sample_loader #(
    parameter int unsigned DW      = 8,
    parameter int unsigned N       = 62,
    parameter int unsigned CW      = 16,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [N*DW-1:0] nn_data,
    output logic          nn_start,
    input  logic          nn_ready,
    input  logic [DW-1:0] nn_class,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_class,
    output logic [DW-1:0] res_label,
    output logic          res_match,
    output logic          res_timeout,
    input  logic          clr_stats,
    output logic [CW-1:0] sample_cnt,
    output logic [CW-1:0] correct_cnt
);

    localparam int unsigned IdxW = $clog2(N + 1);
    localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   CntMax  = '1;

    typedef enum logic [2:0] {StLoad, StStart, StGuard, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic                live_q;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [N*DW-1:0]     feat_q, feat_d;
    logic [DW-1:0]       label_q, label_d;
    logic [DW-1:0]       class_q, class_d;
    logic                timeout_q, timeout_d;
    logic [TmrW-1:0]     tmr_q, tmr_d;
    logic [CW-1:0]       smp_q, smp_d;
    logic [CW-1:0]       cor_q, cor_d;
    logic                in_fire;

    // live_q keeps in_ready low during reset cycles while still decoding from registers only.
    assign in_ready    = live_q && (state_q == StLoad);
    assign nn_start    = (state_q == StStart);
    assign res_valid   = (state_q == StDone);
    assign in_fire     = in_valid && in_ready;

    assign nn_data     = feat_q;
    assign res_class   = class_q;
    assign res_label   = label_q;
    assign res_timeout = timeout_q;
    assign res_match   = !timeout_q && (class_q == label_q);
    assign sample_cnt  = smp_q;
    assign correct_cnt = cor_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        feat_d    = feat_q;
        label_d   = label_q;
        class_d   = class_q;
        timeout_d = timeout_q;
        tmr_d     = tmr_q;
        smp_d     = smp_q;
        cor_d     = cor_q;

        unique case (state_q)
            StLoad: begin
                if (in_fire) begin
                    if (idx_q == LastIdx) begin
                        label_d = in_data;
                        idx_d   = '0;
                        state_d = StStart;
                    end else begin
                        feat_d[int'(idx_q) * DW +: DW] = in_data;
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StStart: state_d = StGuard;
            // nn_ready may still be high from the previous run; never sample it here.
            StGuard: begin
                tmr_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (nn_ready) begin
                    class_d   = nn_class;
                    timeout_d = 1'b0;
                    state_d   = StDone;
                end else if (tmr_q == TmrLast) begin
                    class_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StLoad;
                    if (smp_q != CntMax) smp_d = smp_q + CW'(1);
                    if (res_match && (cor_q != CntMax)) cor_d = cor_q + CW'(1);
                end
            end
            default: state_d = StLoad;
        endcase

        // Clear takes priority over a coincident increment.
        if (clr_stats) begin
            smp_d = '0;
            cor_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StLoad;
            live_q    <= 1'b0;
            idx_q     <= '0;
            feat_q    <= '0;
            label_q   <= '0;
            class_q   <= '0;
            timeout_q <= 1'b0;
            tmr_q     <= '0;
            smp_q     <= '0;
            cor_q     <= '0;
        end else begin
            state_q   <= state_d;
            live_q    <= 1'b1;
            idx_q     <= idx_d;
            feat_q    <= feat_d;
            label_q   <= label_d;
            class_q   <= class_d;
            timeout_q <= timeout_d;
            tmr_q     <= tmr_d;
            smp_q     <= smp_d;
            cor_q     <= cor_d;
        end
    end

endmodule

// File: tb/tb_nn_sample_loader.sv
// Testbench for nn_sample_loader: table-driven sample transactions plus hand-written
// sequences for reset and counter corner cases. A second, small instance free-runs
// to drive its counters into saturation.
module tb_nn_sample_loader;

    localparam int unsigned DW      = 8;
    localparam int unsigned N       = 62;
    localparam int unsigned CW      = 16;
    localparam int unsigned TIMEOUT = 4096;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic [N*DW-1:0] nn_data;
    logic            nn_start;
    logic            nn_ready;
    logic [DW-1:0]   nn_class;
    logic            res_valid;
    logic            res_ready;
    logic [DW-1:0]   res_class;
    logic [DW-1:0]   res_label;
    logic            res_match;
    logic            res_timeout;
    logic            clr_stats;
    logic [CW-1:0]   sample_cnt;
    logic [CW-1:0]   correct_cnt;

    always #5 clk = ~clk;

    nn_sample_loader #(.DW(DW), .N(N), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .nn_data     (nn_data),
        .nn_start    (nn_start),
        .nn_ready    (nn_ready),
        .nn_class    (nn_class),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_class   (res_class),
        .res_label   (res_label),
        .res_match   (res_match),
        .res_timeout (res_timeout),
        .clr_stats   (clr_stats),
        .sample_cnt  (sample_cnt),
        .correct_cnt (correct_cnt)
    );

    // Small free-running instance: all-zero samples, network always ready, consumer always
    // ready. Its 2-bit counters must stick at 3 after more than three samples.
    logic        sat_rst;
    logic        sat_in_ready;
    logic [31:0] sat_nn_data;
    logic        sat_nn_start;
    logic        sat_res_valid;
    logic [7:0]  sat_res_class;
    logic [7:0]  sat_res_label;
    logic        sat_res_match;
    logic        sat_res_timeout;
    logic [1:0]  sat_sample_cnt;
    logic [1:0]  sat_correct_cnt;
    int          sat_starts = 0;
    int          sat_results = 0;
    int          sat_accepts = 0;

    nn_sample_loader #(.DW(8), .N(4), .CW(2), .TIMEOUT(8)) u_sat (
        .clk         (clk),
        .rst         (sat_rst),
        .in_valid    (1'b1),
        .in_data     (8'h00),
        .in_ready    (sat_in_ready),
        .nn_data     (sat_nn_data),
        .nn_start    (sat_nn_start),
        .nn_ready    (1'b1),
        .nn_class    (8'h00),
        .res_valid   (sat_res_valid),
        .res_ready   (1'b1),
        .res_class   (sat_res_class),
        .res_label   (sat_res_label),
        .res_match   (sat_res_match),
        .res_timeout (sat_res_timeout),
        .clr_stats   (1'b0),
        .sample_cnt  (sat_sample_cnt),
        .correct_cnt (sat_correct_cnt)
    );

    always @(negedge clk) begin
        if (sat_nn_start) sat_starts++;
        if (sat_res_valid) sat_results++;
        if (sat_in_ready) sat_accepts++;
    end

    typedef struct {
        logic [7:0] seed;
        logic [7:0] label;
        logic [7:0] cls;
        bit         ready;
        bit         bubbles;
        int         hold;
        bit         clr;
        logic [7:0] exp_class;
        bit         exp_match;
        bit         exp_timeout;
    } vec_t;

    vec_t vecs[6];
    vec_t post_vec;

    int n_tests = 0;
    int n_fail  = 0;
    logic [CW-1:0] exp_samples = '0;
    logic [CW-1:0] exp_correct = '0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] exp_feat(input logic [7:0] seed);
        logic [N*DW-1:0] f;
        for (int k = 0; k < N; k++) f[k*DW +: DW] = seed + 8'(k + 1);
        return f;
    endfunction

    // Offers slots 0..count-1; returns #1 after the edge accepting the last one.
    task automatic load_bytes(input logic [7:0] seed, input logic [7:0] label, input int count,
                              input bit bubbles);
        int gap;
        int waited;
        for (int k = 0; k < count; k++) begin
            if (bubbles) begin
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = (k < N) ? seed + 8'(k + 1) : label;
            waited   = 0;
            while (!in_ready && waited < 200) begin
                @(posedge clk); #1;
                waited++;
            end
            if (!in_ready) check("in_ready_wait", {511'b0, in_ready}, 512'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [N*DW-1:0] ef;
        int cyc;
        ef        = exp_feat(v.seed);
        nn_ready  = v.ready;
        nn_class  = v.cls;
        res_ready = 1'b0;
        load_bytes(v.seed, v.label, N + 1, v.bubbles);
        check({tag, " nn_start_on"}, {511'b0, nn_start}, 512'd1);
        check({tag, " nn_data_lo"}, 512'(nn_data[7:0]), 512'(ef[7:0]));
        check({tag, " nn_data_hi"}, 512'(nn_data[495:488]), 512'(ef[495:488]));
        check({tag, " nn_data"}, 512'(nn_data), 512'(ef));
        @(posedge clk); #1;
        check({tag, " nn_start_off"}, {511'b0, nn_start}, 512'd0);
        cyc = 1;
        while (!res_valid && cyc < int'(TIMEOUT) + 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        // START cycle + GUARD cycle, then WAIT: 1 cycle if ready, TIMEOUT cycles otherwise.
        check({tag, " result_latency"}, 512'(cyc), v.ready ? 512'd3 : 512'(TIMEOUT + 2));
        for (int h = 0; h <= v.hold; h++) begin
            check({tag, " res_valid"}, {511'b0, res_valid}, 512'd1);
            check({tag, " res_class"}, 512'(res_class), 512'(v.exp_class));
            check({tag, " res_label"}, 512'(res_label), 512'(v.label));
            check({tag, " res_match"}, {511'b0, res_match}, 512'(v.exp_match));
            check({tag, " res_timeout"}, {511'b0, res_timeout}, 512'(v.exp_timeout));
            check({tag, " in_ready_done"}, {511'b0, in_ready}, 512'd0);
            check({tag, " nn_data_done"}, 512'(nn_data), 512'(ef));
            if (h < v.hold) begin
                @(posedge clk); #1;
            end
        end
        res_ready = 1'b1;
        clr_stats = v.clr;
        if (v.clr) begin
            exp_samples = '0;
            exp_correct = '0;
        end else begin
            if (exp_samples != 16'hFFFF) exp_samples = exp_samples + 16'd1;
            if (v.exp_match && exp_correct != 16'hFFFF) exp_correct = exp_correct + 16'd1;
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        clr_stats = 1'b0;
        check({tag, " res_valid_off"}, {511'b0, res_valid}, 512'd0);
        check({tag, " in_ready_back"}, {511'b0, in_ready}, 512'd1);
        check({tag, " sample_cnt"}, 512'(sample_cnt), 512'(exp_samples));
        check({tag, " correct_cnt"}, 512'(correct_cnt), 512'(exp_correct));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " in_ready"}, {511'b0, in_ready}, 512'd0);
        check({tag, " nn_start"}, {511'b0, nn_start}, 512'd0);
        check({tag, " res_valid"}, {511'b0, res_valid}, 512'd0);
        check({tag, " nn_data"}, 512'(nn_data), 512'd0);
        check({tag, " res_class"}, 512'(res_class), 512'd0);
        check({tag, " res_label"}, 512'(res_label), 512'd0);
        check({tag, " res_timeout"}, {511'b0, res_timeout}, 512'd0);
        check({tag, " sample_cnt"}, 512'(sample_cnt), 512'd0);
        check({tag, " correct_cnt"}, 512'(correct_cnt), 512'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        //           seed   label  cls    rdy bub hold clr exp_cls match tmo
        vecs[0] = '{8'h00, 8'h05, 8'h05, 1, 0, 0, 0, 8'h05, 1, 0};
        vecs[1] = '{8'h0A, 8'h07, 8'h03, 1, 0, 5, 0, 8'h03, 0, 0};
        vecs[2] = '{8'h40, 8'hFF, 8'hFF, 1, 1, 1, 0, 8'hFF, 1, 0};
        vecs[3] = '{8'h80, 8'h80, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0};
        vecs[4] = '{8'h05, 8'h00, 8'h5A, 0, 0, 2, 0, 8'h00, 0, 1};
        vecs[5] = '{8'h01, 8'h22, 8'h22, 1, 0, 0, 1, 8'h22, 1, 0};
        post_vec = '{8'h33, 8'h34, 8'h34, 1, 1, 0, 0, 8'h34, 1, 0};

        rst       = 1'b1;
        sat_rst   = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        nn_ready  = 1'b0;
        nn_class  = '0;
        res_ready = 1'b0;
        clr_stats = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst     = 1'b0;
        sat_rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_reset", {511'b0, in_ready}, 512'd1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort a partial, bubbly load with reset; nothing must survive it.
        load_bytes(8'h60, 8'h00, 31, 1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(posedge clk); #1;
        check_reset_values("midreset");
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_samples = '0;
        exp_correct = '0;
        @(posedge clk); #1;
        check("in_ready_after_midreset", {511'b0, in_ready}, 512'd1);
        check("nn_start_after_midreset", {511'b0, nn_start}, 512'd0);
        run_vec(post_vec, "post");

        // Saturation of the small instance.
        check("sat_starts", 512'(sat_starts > 4), 512'd1);
        check("sat_handshakes", 512'((sat_results > 4) && (sat_accepts > 4)), 512'd1);
        check("sat_sample_cnt", 512'(sat_sample_cnt), 512'd3);
        check("sat_correct_cnt", 512'(sat_correct_cnt), 512'd3);
        check("sat_results", {sat_nn_data, sat_res_class, sat_res_label, sat_res_timeout,
                              sat_res_match}, 512'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
